ws2812b_chain: RTL

- Parametrised successor to the single-pixel WS2812B driver.
- Drives a daisy-chain of N_LEDS pixels from an internal frame buffer.
- The frame buffer is written through a simple addressed write port, normally fed from the I2C slave register file.
- Adds start/busy/done handshake, cycle-programmable bit timing, a latch/reset gap, and an optional auto-refresh mode.

---
 rtl/ws2812b_chain.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ws2812b_chain.sv
// WS2812B daisy-chain driver: streams N_LEDS GRB pixels from an internal frame
// buffer with programmable bit timing, a latch gap and optional auto-refresh.
module ws2812b_chain #(
  parameter int N_LEDS       = 8,
  parameter int ADDR_W       = 3,
  parameter int BIT_CYC      = 15,
  parameter int T0H_CYC      = 4,
  parameter int T1H_CYC      = 9,
  parameter int RST_CYC      = 720,
  parameter int AUTO_REFRESH = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sig,
  output logic [2:0]        dbg_state
);

  // Handshake: start is a one-cycle request honoured only while idle and busy=0
  // (never queued); busy covers the whole frame incl. the latch gap; done pulses
  // once when the gap completes. sig/busy/done are registered from the state.

  localparam int CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int LAT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam int PIX_W = (N_LEDS > 1)  ? $clog2(N_LEDS)  : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [23:0]        r_fb [N_LEDS];
  logic [23:0]        r_shift;
  logic [CYC_W-1:0]   r_cyc;
  logic [4:0]         r_bit;
  logic [PIX_W-1:0]   r_pix;
  logic [LAT_W-1:0]   r_lat;
  logic               r_sig;
  logic               r_busy;
  logic               r_done;

  logic [CYC_W-1:0]   w_hi_last;
  logic               w_hi_end;
  logic               w_bit_end;
  logic               w_last_bit;
  logic               w_last_pix;
  logic               w_lat_end;
  logic [PIX_W-1:0]   w_load_idx;
  logic [23:0]        w_load_word;
  logic [23:0]        w_load_grb;

  assign busy      = r_busy;
  assign done      = r_done;
  assign sig       = r_sig;
  assign dbg_state = r_state;

  assign w_hi_last  = r_shift[23] ? CYC_W'(T1H_CYC - 1) : CYC_W'(T0H_CYC - 1);
  assign w_hi_end   = (r_cyc == w_hi_last);
  assign w_bit_end  = (r_cyc == CYC_W'(BIT_CYC - 1));
  assign w_last_bit = (r_bit == 5'd23);
  assign w_last_pix = (r_pix == PIX_W'(N_LEDS - 1));
  assign w_lat_end  = (r_lat == LAT_W'(RST_CYC - 1));

  // Word stored as {R,G,B}; the wire wants G first.
  assign w_load_grb = {w_load_word[15:8], w_load_word[23:16], w_load_word[7:0]};

  always_comb begin
    w_load_idx  = (r_state == S_LOAD) ? '0 : r_pix + PIX_W'(1);
    w_load_word = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (w_load_idx == PIX_W'(i)) w_load_word = r_fb[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if ((AUTO_REFRESH != 0) || (start && !r_busy)) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_HIGH;
      S_HIGH:  if (w_hi_end) w_state_nxt = S_LOW;
      S_LOW: begin
        if (w_bit_end) begin
          w_state_nxt = (w_last_bit && w_last_pix) ? S_LATCH : S_HIGH;
        end
      end
      S_LATCH: begin
        if (w_lat_end) w_state_nxt = (AUTO_REFRESH != 0) ? S_LOAD : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_pix   <= '0;
      r_lat   <= '0;
      r_sig   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < N_LEDS; i++) r_fb[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sig   <= (r_state == S_HIGH);
      r_busy  <= (r_state != S_IDLE);
      r_done  <= (r_state == S_LATCH) && w_lat_end;

      for (int i = 0; i < N_LEDS; i++) begin
        if (wr_en && (wr_addr == ADDR_W'(i))) r_fb[i] <= wr_data;
      end

      // r_cyc spans HIGH and LOW so the pair always totals BIT_CYC.
      if ((r_state == S_HIGH) || ((r_state == S_LOW) && !w_bit_end)) begin
        r_cyc <= r_cyc + CYC_W'(1);
      end else begin
        r_cyc <= '0;
      end

      r_lat <= ((r_state == S_LATCH) && !w_lat_end) ? r_lat + LAT_W'(1) : '0;

      case (r_state)
        S_LOAD: begin
          r_shift <= w_load_grb;
          r_bit   <= '0;
          r_pix   <= '0;
        end
        S_LOW: begin
          if (w_bit_end) begin
            if (w_last_bit) begin
              r_bit <= '0;
              if (!w_last_pix) begin
                r_pix   <= r_pix + PIX_W'(1);
                r_shift <= w_load_grb;
              end
            end else begin
              r_bit   <= r_bit + 5'd1;
              r_shift <= {r_shift[22:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
